// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU pattern codes driven on alu_pattern (ALU_PASS..ALU_NOR = 0..9)
//   - MIPS opcode / funct constants for the supported subset
//   - issue_t: decoded entry carried through the issue buffer
package alu_pkg;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  pattern;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } issue_t;

  localparam issue_t ISSUE_RESET = '0;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational decode of one MIPS-subset instruction
// and its register operands into an issue_t entry.
//   instr_i  : instruction word
//   rs_val_i : value of GPR[rs]
//   rt_val_i : value of GPR[rt]
//   issue_o  : ALU operands, pattern and writeback control
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output issue_t      issue_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  issue_t      dec;

  // The rs index is not needed: its value already arrives as rs_val_i.
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr_i[25:21];

  assign opcode   = instr_i[31:26];
  assign rt_idx   = instr_i[20:16];
  assign rd_idx   = instr_i[15:11];
  assign shamt    = instr_i[10:6];
  assign funct    = instr_i[5:0];
  assign imm_sext = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_zext = {16'h0000, instr_i[15:0]};

  always_comb begin
    dec = ISSUE_RESET;
    if (opcode == OP_RTYPE) begin
      // Common R-type fields; cleared again below if the funct is unknown.
      dec.a  = rs_val_i;
      dec.b  = rt_val_i;
      dec.rd = rd_idx;
      dec.we = 1'b1;
      case (funct)
        FN_ADD, FN_ADDU: dec.pattern = ALU_ADD;
        FN_SUB, FN_SUBU: dec.pattern = ALU_SUB;
        FN_AND:          dec.pattern = ALU_AND;
        FN_OR:           dec.pattern = ALU_OR;
        FN_NOR:          dec.pattern = ALU_NOR;
        FN_SLT:          dec.pattern = ALU_SLT;
        FN_SLL: begin dec.a = {27'd0, shamt}; dec.pattern = ALU_SLL; end
        FN_SRL: begin dec.a = {27'd0, shamt}; dec.pattern = ALU_SRL; end
        FN_SRA: begin dec.a = {27'd0, shamt}; dec.pattern = ALU_SRA; end
        FN_SLLV:         dec.pattern = ALU_SLL;
        FN_SRLV:         dec.pattern = ALU_SRL;
        FN_SRAV:         dec.pattern = ALU_SRA;
        default: begin
          dec         = ISSUE_RESET;
          dec.illegal = 1'b1;
        end
      endcase
    end else begin
      dec.a  = rs_val_i;
      dec.rd = rt_idx;
      dec.we = 1'b1;
      case (opcode)
        OP_ADDI, OP_ADDIU: begin dec.b = imm_sext; dec.pattern = ALU_ADD; end
        OP_SLTI:           begin dec.b = imm_sext; dec.pattern = ALU_SLT; end
        OP_ANDI:           begin dec.b = imm_zext; dec.pattern = ALU_AND; end
        OP_ORI:            begin dec.b = imm_zext; dec.pattern = ALU_OR;  end
        // lui is executed as imm << 16 on the shifter.
        OP_LUI: begin
          dec.a       = 32'd16;
          dec.b       = imm_zext;
          dec.pattern = ALU_SLL;
        end
        OP_LW:  begin dec.b = imm_sext; dec.pattern = ALU_ADD; end
        OP_SW:  begin dec.b = imm_sext; dec.pattern = ALU_ADD; dec.we = 1'b0; end
        default: begin
          dec         = ISSUE_RESET;
          dec.illegal = 1'b1;
        end
      endcase
    end
    // $0 is hardwired; never request a write to it.
    if (dec.rd == 5'd0) dec.we = 1'b0;
  end

  assign issue_o = dec;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue stage between register read and the execute ALU.
// Decodes the incoming instruction and holds decoded entries in a
// 2-entry in-order valid/ready skid buffer (head drives the outputs).
//   clk, rstn (async active-low), flush (sync, drops everything)
//   in_valid/in_ready, in_instr, in_rs_val, in_rt_val : upstream side
//   out_valid/out_ready, data_a, data_b, alu_pattern,
//   out_rd, out_we, out_illegal                        : ALU side
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic [3:0]  alu_pattern,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_illegal
);

  issue_t     dec;
  issue_t     head_q, head_d;
  issue_t     skid_q, skid_d;
  logic [1:0] occ_q, occ_d;
  logic       accept;
  logic       retire;

  alu_decode u_decode (
    .instr_i  (in_instr),
    .rs_val_i (in_rs_val),
    .rt_val_i (in_rt_val),
    .issue_o  (dec)
  );

  // in_ready depends only on registered occupancy, so out_ready never
  // reaches it combinationally.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (flush) begin
      // Payload registers keep their contents; only occupancy clears.
      occ_d = 2'd0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (accept) begin
            head_d = dec;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          case ({accept, retire})
            2'b10: begin skid_d = dec; occ_d = 2'd2; end
            2'b01: occ_d = 2'd0;
            2'b11: head_d = dec;
            default: ;
          endcase
        end
        2'd2: begin
          if (retire) begin
            head_d = skid_q;
            occ_d  = 2'd1;
          end
        end
        default: occ_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= ISSUE_RESET;
      skid_q <= ISSUE_RESET;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
    end
  end

  assign data_a      = head_q.a;
  assign data_b      = head_q.b;
  assign alu_pattern = head_q.pattern;
  assign out_rd      = head_q.rd;
  assign out_we      = head_q.we;
  assign out_illegal = head_q.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage that sits between register read and the execute-stage ALU. It decodes a MIPS-subset instruction and its register operands into the ALU operand pair, the 4-bit ALU pattern, and writeback control, and holds the result in a 2-entry valid/ready skid buffer. It is the producing end of the ALU's `data_a` / `data_b` / `alu_pattern` interface.

## Interface
- No parameters; all widths are fixed at 32-bit data and 5-bit register indices.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; drops all buffered and incoming entries.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept an entry.
- `in_instr` in 32: instruction word.
- `in_rs_val` in 32: value of GPR[rs].
- `in_rt_val` in 32: value of GPR[rt].
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: execute stage accepts the head entry.
- `data_a` out 32: ALU operand A; this is the shift amount for shifts.
- `data_b` out 32: ALU operand B; this is the shifted value for shifts.
- `alu_pattern` out 4: 0 pass A, 1 add, 2 and, 3 or, 4 sll, 5 srl, 6 sub, 7 sra, 8 slt, 9 nor.
- `out_rd` out 5: destination register.
- `out_we` out 1: register write enable.
- `out_illegal` out 1: unsupported encoding.

## Operation
- **R-type (opcode 0x00)**: A=rs_val, B=rt_val, rd=instr[15:11], we=1. Funct mapping:
  - 0x20/0x21 → 1
  - 0x22/0x23 → 6
  - 0x24 → 2
  - 0x25 → 3
  - 0x27 → 9
  - 0x2A → 8
- **Immediate shifts**: sll 0x00, srl 0x02, sra 0x03 give A={27'b0,shamt}, B=rt_val, pattern 4/5/7.
- **Variable shifts**: sllv 0x04, srlv 0x06, srav 0x07 give A=rs_val, B=rt_val, pattern 4/5/7.
- **I-type**: A=rs_val, rd=instr[20:16], we=1.
  - addi 0x08 and addiu 0x09: B=sext(imm), pattern 1.
  - slti 0x0A: B=sext(imm), pattern 8.
  - andi 0x0C: B=zext(imm), pattern 2.
  - ori 0x0D: B=zext(imm), pattern 3.
- **lui 0x0F**: A=32'd16, B=zext(imm), pattern 4, rd=rt, we=1.
- **lw 0x23**: A=rs_val, B=sext(imm), pattern 1, rd=rt, we=1.
- **sw 0x2B**: same as lw but we=0.
- **Any other opcode/funct**: illegal=1, we=0, pattern 0, A=B=0, rd=0. The entry still flows so the trap is taken in order.
- Any entry whose rd is 0 has we forced to 0.
- **Buffer**: FIFO with depth 2, in-order. It holds a head register, which drives the outputs, plus a skid register.
  - Accept on `in_valid & in_ready`.
  - Retire on `out_valid & out_ready`.
  - Simultaneous accept and retire at occupancy 1: head gets the new entry, occupancy stays 1.
  - Accept at occupancy 2 cannot occur, because in_ready=0 there.
- **Flush**: occupancy goes to 0 next edge. An entry presented in the same cycle is dropped, and flush takes priority over accept. in_ready=1 the cycle after.

## Timing
- Latency: accept at edge N puts the entry on the outputs after edge N (out_valid=1), provided the buffer was empty or draining.
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready = (occupancy < 2), derived from registered state only. No combinational path from out_ready to in_ready.
- Outputs are stable while out_valid=1 and out_ready=0.
- Data outputs hold their last value when out_valid=0; only out_valid is authoritative.
- Reset (rstn low, any time, including mid-transfer):
  - out_valid=0, in_ready=1, occupancy=0.
  - data_a=0, data_b=0, alu_pattern=0, out_rd=0, out_we=0, out_illegal=0.
  - Buffered entries are lost.

## Structure
- Package `alu_pkg`:
  - ALU pattern constants (ALU_PASS…ALU_NOR = 0..9).
  - Opcode and funct constants.
  - Packed struct `issue_t` with fields a, b, pattern, rd, we, illegal.
- Sub-module `alu_decode`: purely combinational, instr + rs_val + rt_val → issue_t. Instantiated once on the input side.
- `alu_issue` contains only the 2-entry buffer and its control.

## Test plan
- add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 → next cycle out_valid=1, A=5, B=7, pattern=1, rd=3, we=1.
- sll $4,$2,3 (0x000220C0), rt=0x0F → A=3, B=0x0F, pattern=4, rd=4. lui $5,0x1234 (0x3C051234) → A=16, B=0x00001234, pattern=4, rd=5.
- addi $6,$1,-1 (0x2026FFFF), rs=10 → A=10, B=0xFFFFFFFF, pattern=1, we=1. sw (0xAC220004) → B=4, we=0.
- out_ready=0, three back-to-back entries:
  - first two are accepted and in_ready drops after the second; the third is held upstream;
  - outputs stay frozen while stalled;
  - on release, all three retire in order over 3 cycles.
- Occupancy 2 plus flush with in_valid=1 → next cycle out_valid=0, in_ready=1; none of the three entries ever appear.
- Opcode 0x3F (0xFC000000) → illegal=1, we=0, pattern=0. Asserting rstn=0 mid-stall clears all outputs to the reset values.
